cpu_in_port: RTL and testbench

//  Input port for the 8-bit cpu: the receive-side counterpart of its o_data output path.

---
 rtl/cpu_in_port.sv | 55 +++++
 tb/tb_cpu_in_port.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_in_port.sv
// cpu_in_port: valid/ready receive FIFO feeding the cpu input mux with a first-word fall-through head.
module cpu_in_port #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic [DATA_W-1:0]          ext_data,
    input  logic                       ext_valid,
    output logic                       ext_ready,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          i_data,
    output logic                       data_avail,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       underrun,
    input  logic                       err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              underrun_q, underrun_d;
    logic              push, pop;
    assign ext_ready  = count_q != CW'(DEPTH);
    assign data_avail = count_q != '0;
    assign i_data     = data_avail ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;
    assign underrun   = underrun_q;
    always_comb begin
        push       = ext_valid & ext_ready;
        pop        = rd_en & data_avail;
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + CW'(push) - CW'(pop);
        underrun_d = (rd_en & ~data_avail) | (underrun_q & ~err_clr);
    end
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            underrun_q <= underrun_d;
        end
    end
    // Storage is deliberately not reset; count gates it off i_data.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= ext_data;
    end
endmodule

// File: tb/tb_cpu_in_port.sv
// tb_cpu_in_port: directed checks of the cpu input FIFO port.
module tb_cpu_in_port;
    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] ext_data = 8'h00;
    logic       ext_valid = 1'b0;
    logic       ext_ready;
    logic       rd_en = 1'b0;
    logic [7:0] i_data;
    logic       data_avail;
    logic [2:0] count;
    logic       underrun;
    logic       err_clr = 1'b0;
    int n_cmp = 0;
    int n_fail = 0;

    cpu_in_port #(.DATA_W(8), .DEPTH(4)) dut (
        .clk(clk), .clr(clr), .ext_data(ext_data), .ext_valid(ext_valid), .ext_ready(ext_ready),
        .rd_en(rd_en), .i_data(i_data), .data_avail(data_avail), .count(count),
        .underrun(underrun), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        tick();
        tick();
        n_cmp++; if (ext_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ext_ready); end
        n_cmp++; if (data_avail !== 1'b0) begin n_fail++; $display("FAIL reset_avail: got %b want 0", data_avail); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (i_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", i_data); end
        n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        clr = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            ext_valid = 1'b1;
            ext_data  = vals[i];
            tick();
            n_cmp++; if (i_data !== 8'h11) begin n_fail++; $display("FAIL fill_head[%0d]: got %h want 11", i, i_data); end
            n_cmp++; if (count !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
        end
        n_cmp++; if (ext_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready: got %b want 0", ext_ready); end
        ext_data = 8'h55;
        tick();
        tick();
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_stall_count: got %0d want 4", count); end
        n_cmp++; if (i_data !== 8'h11) begin n_fail++; $display("FAIL fill_stall_head: got %h want 11", i_data); end
    endtask

    task automatic test_drain();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        ext_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (i_data !== vals[i]) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, i_data, vals[i]); end
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        n_cmp++; if (data_avail !== 1'b0) begin n_fail++; $display("FAIL drain_avail: got %b want 0", data_avail); end
        n_cmp++; if (i_data !== 8'h00) begin n_fail++; $display("FAIL drain_data_empty: got %h want 00", i_data); end
        n_cmp++; if (ext_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready: got %b want 1", ext_ready); end
        ext_valid = 1'b1;
        ext_data  = 8'h55;
        tick();
        ext_valid = 1'b0;
        n_cmp++; if (i_data !== 8'h55) begin n_fail++; $display("FAIL drain_late_word: got %h want 55", i_data); end
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL drain_late_count: got %0d want 1", count); end
    endtask

    task automatic test_simultaneous();
        ext_valid = 1'b1;
        ext_data  = 8'h66;
        tick();
        ext_data = 8'hA5;
        rd_en    = 1'b1;
        tick();
        rd_en = 1'b0;
        n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL simul_count: got %0d want 2", count); end
        n_cmp++; if (i_data !== 8'h66) begin n_fail++; $display("FAIL simul_head: got %h want 66", i_data); end
        ext_data = 8'h77;
        tick();
        ext_data = 8'h88;
        tick();
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL simul_full: got %0d want 4", count); end
        ext_data = 8'h99;
        rd_en    = 1'b1;
        tick();
        ext_valid = 1'b0;
        n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL simul_full_pop_count: got %0d want 3", count); end
        n_cmp++; if (ext_ready !== 1'b1) begin n_fail++; $display("FAIL simul_full_pop_ready: got %b want 1", ext_ready); end
        n_cmp++; if (i_data !== 8'hA5) begin n_fail++; $display("FAIL simul_full_pop_head: got %h want a5", i_data); end
        tick();
        n_cmp++; if (i_data !== 8'h77) begin n_fail++; $display("FAIL simul_order_77: got %h want 77", i_data); end
        tick();
        n_cmp++; if (i_data !== 8'h88) begin n_fail++; $display("FAIL simul_order_88: got %h want 88", i_data); end
        tick();
        rd_en = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL simul_refused_word: got count %0d want 0", count); end
    endtask

    task automatic test_wrap();
        ext_valid = 1'b1;
        ext_data  = 8'h01;
        tick();
        for (int i = 2; i <= 10; i++) begin
            ext_data = 8'(i);
            rd_en    = 1'b1;
            n_cmp++; if (i_data !== 8'(i - 1)) begin n_fail++; $display("FAIL wrap_order[%0d]: got %h want %h", i - 1, i_data, 8'(i - 1)); end
            tick();
            n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d want 1", i, count); end
        end
        ext_valid = 1'b0;
        n_cmp++; if (i_data !== 8'h0A) begin n_fail++; $display("FAIL wrap_last: got %h want 0a", i_data); end
        tick();
        rd_en = 1'b0;
        n_cmp++; if (data_avail !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: got %b want 0", data_avail); end
        n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL wrap_no_underrun: got %b want 0", underrun); end
    endtask

    task automatic test_underrun_reset();
        rd_en = 1'b1;
        tick();
        n_cmp++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_set: got %b want 1", underrun); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL underrun_count: got %0d want 0", count); end
        err_clr = 1'b1;
        tick();
        n_cmp++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_set_wins: got %b want 1", underrun); end
        rd_en = 1'b0;
        tick();
        err_clr = 1'b0;
        n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_clear: got %b want 0", underrun); end
        ext_valid = 1'b1;
        ext_data  = 8'hC3;
        rd_en     = 1'b1;
        tick();
        rd_en = 1'b0;
        n_cmp++; if (i_data !== 8'hC3) begin n_fail++; $display("FAIL empty_push_pop_data: got %h want c3", i_data); end
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL empty_push_pop_count: got %0d want 1", count); end
        n_cmp++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL empty_push_pop_underrun: got %b want 1", underrun); end
        ext_data = 8'hD4;
        err_clr  = 1'b1;
        tick();
        err_clr  = 1'b0;
        ext_data = 8'hE5;
        tick();
        ext_valid = 1'b0;
        n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL midfill_count: got %0d want 3", count); end
        clr = 1'b1;
        #1;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL async_clr_count: got %0d want 0", count); end
        n_cmp++; if (data_avail !== 1'b0) begin n_fail++; $display("FAIL async_clr_avail: got %b want 0", data_avail); end
        n_cmp++; if (i_data !== 8'h00) begin n_fail++; $display("FAIL async_clr_data: got %h want 00", i_data); end
        tick();
        clr = 1'b0;
        tick();
        n_cmp++; if (ext_ready !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL post_clr: got ready %b count %0d want 1 0", ext_ready, count); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_underrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
